lamp_sequence_monitor: RTL and testbench

Receive-side checker for the three-lamp traffic light bus driven by the cyclic lamp generator. It samples the one-hot `light` vector on every enabled clock and decodes it to a colour code. It verifies that the red→yellow→green→red order holds, locks once the sequence is stable, and reports encoding errors, ordering errors, completed cycles and a saturating error tally. It sits beside the lamp driver as a self-check and status source for the surrounding controller.

---
 rtl/lamp_sequence_monitor_if.sv | 25 ++
 rtl/lamp_sequence_monitor.sv | 145 ++++++++++++++
 tb/tb_lamp_sequence_monitor.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lamp_sequence_monitor_if.sv
// rtl/lamp_sequence_monitor_if.sv - lamp bus and status signals between lamp side and monitor
interface lamp_sequence_monitor_if #(
    parameter int CNT_W = 8
);
    logic             enable;
    logic [0:2]       light;
    logic [1:0]       color;
    logic             locked;
    logic             err_code;
    logic             err_seq;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] err_count;

    // Lamp driver / environment side
    modport master (
        output enable, light,
        input  color, locked, err_code, err_seq, cycle_count, err_count
    );

    // Monitor side
    modport slave (
        input  enable, light,
        output color, locked, err_code, err_seq, cycle_count, err_count
    );
endinterface

// File: rtl/lamp_sequence_monitor.sv
// rtl/lamp_sequence_monitor.sv - red/yellow/green lamp order checker with lock and error tally
module lamp_sequence_monitor #(
    parameter int CNT_W      = 8,
    parameter int LOCK_LEN   = 3,
    parameter int ALLOW_HOLD = 0
) (
    input logic                   clock,
    input logic                   reset,
    lamp_sequence_monitor_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [1:0] RED     = 2'd0;
    localparam logic [1:0] GREEN   = 2'd2;
    localparam logic [1:0] INVALID = 2'd3;

    state_t           state_q, state_next;
    logic [1:0]       prev_q, prev_next;
    logic [3:0]       run_q, run_next;
    logic [1:0]       color_q, color_next;
    logic             locked_q;
    logic             err_code_q, err_code_next;
    logic             err_seq_q, err_seq_next;
    logic [CNT_W-1:0] cycle_q, cycle_next;
    logic [CNT_W-1:0] errs_q, errs_next;

    logic [1:0] code;
    logic       code_valid;
    logic [1:0] succ;
    logic       legal;
    logic       hold_ok;
    logic [3:0] run_inc;

    // Decode the lamp vector and classify the sample against the previous colour
    always_comb begin
        case (bus.light)
            3'b100:  code = 2'd0;
            3'b010:  code = 2'd1;
            3'b001:  code = 2'd2;
            default: code = INVALID;
        endcase
        code_valid = (code != INVALID);
        succ       = (prev_q == GREEN) ? RED : prev_q + 2'd1;
        legal      = code_valid && (code == succ);
        hold_ok    = code_valid && (code == prev_q) && (ALLOW_HOLD != 0);
        run_inc    = run_q + 4'd1;
    end

    // State register plus all status registers; reset wins over enable
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            prev_q     <= 2'd0;
            run_q      <= 4'd0;
            color_q    <= INVALID;
            locked_q   <= 1'b0;
            err_code_q <= 1'b0;
            err_seq_q  <= 1'b0;
            cycle_q    <= '0;
            errs_q     <= '0;
        end else begin
            state_q    <= state_next;
            prev_q     <= prev_next;
            run_q      <= run_next;
            color_q    <= color_next;
            locked_q   <= (state_next == LOCKED);
            err_code_q <= err_code_next;
            err_seq_q  <= err_seq_next;
            cycle_q    <= cycle_next;
            errs_q     <= errs_next;
        end
    end

    // Next-state: any invalid code drops tracking, illegal order while locked falls back to TRACK
    always_comb begin
        state_next = state_q;
        if (bus.enable) begin
            if (!code_valid) begin
                state_next = IDLE;
            end else begin
                case (state_q)
                    IDLE:    state_next = TRACK;
                    TRACK:   if (legal && (run_inc == 4'(LOCK_LEN))) state_next = LOCKED;
                    LOCKED:  if (!legal && !hold_ok) state_next = TRACK;
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    // Output/datapath next values: colour, run length, error pulses and counters
    always_comb begin
        prev_next     = prev_q;
        run_next      = run_q;
        color_next    = color_q;
        err_code_next = 1'b0;
        err_seq_next  = 1'b0;
        cycle_next    = cycle_q;
        errs_next     = errs_q;
        if (bus.enable) begin
            color_next = code;
            if (!code_valid) begin
                err_code_next = 1'b1;
            end else begin
                prev_next = code;
                case (state_q)
                    IDLE: run_next = 4'd0;
                    TRACK: begin
                        if (legal) begin
                            run_next = run_inc;
                        end else if (!hold_ok) begin
                            run_next = 4'd0;
                        end
                    end
                    LOCKED: begin
                        if (legal) begin
                            // Only wrap-arounds seen while already locked count as full cycles
                            if ((prev_q == GREEN) && (code == RED)) begin
                                cycle_next = cycle_q + CNT_W'(1);
                            end
                        end else if (!hold_ok) begin
                            err_seq_next = 1'b1;
                            run_next     = 4'd0;
                        end
                    end
                    default: run_next = 4'd0;
                endcase
            end
            if ((err_code_next || err_seq_next) && (errs_q != {CNT_W{1'b1}})) begin
                errs_next = errs_q + CNT_W'(1);
            end
        end
    end

    assign bus.color       = color_q;
    assign bus.locked      = locked_q;
    assign bus.err_code    = err_code_q;
    assign bus.err_seq     = err_seq_q;
    assign bus.cycle_count = cycle_q;
    assign bus.err_count   = errs_q;
endmodule

// File: tb/tb_lamp_sequence_monitor.sv
// tb/tb_lamp_sequence_monitor.sv - scoreboard bench for lamp_sequence_monitor
module tb_lamp_sequence_monitor;
    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    // Instance a: defaults. Instance b: 4-bit counters with holds allowed.
    lamp_sequence_monitor_if #(.CNT_W(8)) ifa ();
    lamp_sequence_monitor_if #(.CNT_W(4)) ifb ();

    lamp_sequence_monitor #(.CNT_W(8), .LOCK_LEN(3), .ALLOW_HOLD(0)) dut_a (
        .clock(clock),
        .reset(reset),
        .bus  (ifa)
    );

    lamp_sequence_monitor #(.CNT_W(4), .LOCK_LEN(3), .ALLOW_HOLD(1)) dut_b (
        .clock(clock),
        .reset(reset),
        .bus  (ifb)
    );

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    typedef struct {
        int st;
        int prev;
        int run;
        int color;
        bit locked;
        bit ec;
        bit es;
        int cyc;
        int errc;
    } mdl_t;

    typedef struct {
        mdl_t a;
        mdl_t b;
    } pair_t;

    mdl_t  ma, mb;
    pair_t sb[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    ec_pulses;

    function automatic mdl_t reset_model();
        mdl_t r;
        r = '{default: 0};
        r.color = 3;
        return r;
    endfunction

    // Behavioural reference: st 0=idle 1=track 2=locked
    function automatic mdl_t model(input mdl_t m, input logic [2:0] l, input bit en,
                                   input bit rst, input bit hold_ok, input int cmax);
        mdl_t r;
        int   c;
        bit   legal;
        bit   same;
        if (rst) return reset_model();
        r = m;
        r.ec = 0;
        r.es = 0;
        if (!en) return r;
        case (l)
            3'b100:  c = 0;
            3'b010:  c = 1;
            3'b001:  c = 2;
            default: c = 3;
        endcase
        r.color = c;
        if (c == 3) begin
            r.ec = 1;
            r.st = 0;
        end else begin
            legal = (c == (m.prev + 1) % 3);
            same  = (c == m.prev);
            if (m.st == 0) begin
                r.st  = 1;
                r.run = 0;
            end else if (m.st == 1) begin
                if (legal) begin
                    r.run = m.run + 1;
                    if (r.run == 3) r.st = 2;
                end else if (!(same && hold_ok)) begin
                    r.run = 0;
                end
            end else begin
                if (legal) begin
                    if (m.prev == 2 && c == 0) r.cyc = (m.cyc + 1) % (cmax + 1);
                end else if (!(same && hold_ok)) begin
                    r.es  = 1;
                    r.run = 0;
                    r.st  = 1;
                end
            end
            r.prev = c;
        end
        if ((r.ec || r.es) && r.errc < cmax) r.errc = r.errc + 1;
        r.locked = (r.st == 2);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one sample on the falling edge, predict, then compare just after the rising edge
    task automatic step(input logic [2:0] l, input bit en, input bit rst);
        pair_t p;
        pair_t e;
        @(negedge clock);
        reset      = rst;
        ifa.enable = en;
        ifb.enable = en;
        ifa.light  = l;
        ifb.light  = l;
        ma  = model(ma, l, en, rst, 1'b0, 255);
        mb  = model(mb, l, en, rst, 1'b1, 15);
        p.a = ma;
        p.b = mb;
        sb.push_back(p);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        chk("a.color",  32'(ifa.color),       32'(e.a.color));
        chk("a.locked", 32'(ifa.locked),      32'(e.a.locked));
        chk("a.ecode",  32'(ifa.err_code),    32'(e.a.ec));
        chk("a.eseq",   32'(ifa.err_seq),     32'(e.a.es));
        chk("a.cycles", 32'(ifa.cycle_count), 32'(e.a.cyc));
        chk("a.errs",   32'(ifa.err_count),   32'(e.a.errc));
        chk("b.color",  32'(ifb.color),       32'(e.b.color));
        chk("b.locked", 32'(ifb.locked),      32'(e.b.locked));
        chk("b.ecode",  32'(ifb.err_code),    32'(e.b.ec));
        chk("b.eseq",   32'(ifb.err_seq),     32'(e.b.es));
        chk("b.cycles", 32'(ifb.cycle_count), 32'(e.b.cyc));
        chk("b.errs",   32'(ifb.err_count),   32'(e.b.errc));
    endtask

    task automatic run_rgy(input int n);
        logic [2:0] seq [3];
        seq[0] = R;
        seq[1] = Y;
        seq[2] = G;
        for (int i = 0; i < n; i++) step(seq[i % 3], 1'b1, 1'b0);
    endtask

    initial begin
        logic [2:0] seq [3];
        logic [2:0] l;
        seq[0] = R;
        seq[1] = Y;
        seq[2] = G;
        ma = reset_model();
        mb = reset_model();
        ifa.enable = 1'b0;
        ifb.enable = 1'b0;
        ifa.light  = 3'b000;
        ifb.light  = 3'b000;

        // Reset state
        step(R, 1'b1, 1'b1);
        step(R, 1'b1, 1'b1);
        chk("rst.color",  32'(ifa.color),       32'd3);
        chk("rst.locked", 32'(ifa.locked),      32'd0);
        chk("rst.cycles", 32'(ifa.cycle_count), 32'd0);
        chk("rst.errs",   32'(ifa.err_count),   32'd0);

        // Clean R,Y,G stream: lock on 4th sample, cycles 2 after 12 and 3 after 13
        for (int i = 1; i <= 13; i++) begin
            step(seq[(i - 1) % 3], 1'b1, 1'b0);
            chk("s1.color", 32'(ifa.color), 32'((i - 1) % 3));
            if (i == 3)  chk("s1.lock3",  32'(ifa.locked),      32'd0);
            if (i == 4)  chk("s1.lock4",  32'(ifa.locked),      32'd1);
            if (i == 12) chk("s1.cyc12",  32'(ifa.cycle_count), 32'd2);
            if (i == 13) chk("s1.cyc13",  32'(ifa.cycle_count), 32'd3);
        end
        chk("s1.errs", 32'(ifa.err_count), 32'd0);

        // Ordering error while locked: ... R then G
        run_rgy(0);
        step(Y, 1'b1, 1'b0);
        step(G, 1'b1, 1'b0);
        step(R, 1'b1, 1'b0);
        step(G, 1'b1, 1'b0);
        chk("s2.eseq",   32'(ifa.err_seq),   32'd1);
        chk("s2.locked", 32'(ifa.locked),    32'd0);
        chk("s2.errs",   32'(ifa.err_count), 32'd1);
        step(R, 1'b1, 1'b0);
        step(Y, 1'b1, 1'b0);
        step(G, 1'b1, 1'b0);
        chk("s2.relock", 32'(ifa.locked), 32'd1);

        // Encoding error while locked
        step(R, 1'b1, 1'b0);
        step(3'b110, 1'b1, 1'b0);
        chk("s3.ecode",  32'(ifa.err_code), 32'd1);
        chk("s3.color",  32'(ifa.color),    32'd3);
        chk("s3.locked", 32'(ifa.locked),   32'd0);
        step(R, 1'b1, 1'b0);
        chk("s3.ecode0", 32'(ifa.err_code), 32'd0);
        step(Y, 1'b1, 1'b0);
        step(G, 1'b1, 1'b0);
        step(R, 1'b1, 1'b0);
        chk("s3.relock", 32'(ifa.locked), 32'd1);

        // Repeat of a colour while locked: error without hold, silent with hold
        step(R, 1'b1, 1'b0);
        chk("s4.a.eseq",   32'(ifa.err_seq), 32'd1);
        chk("s4.b.eseq",   32'(ifb.err_seq), 32'd0);
        chk("s4.b.locked", 32'(ifb.locked),  32'd1);

        // 20 dark samples: one err_code each, 4-bit tally saturates at 15
        ec_pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step(3'b000, 1'b1, 1'b0);
            if (ifb.err_code === 1'b1) ec_pulses++;
        end
        chk("s5.pulses", 32'(ec_pulses),     32'd20);
        chk("s5.sat",    32'(ifb.err_count), 32'd15);

        // Re-lock, gap in enable mid-cycle, resume without error
        run_rgy(4);
        step(Y, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(3'($urandom_range(0, 7)), 1'b0, 1'b0);
            chk("s6.frozen", 32'(ifa.color), 32'd1);
        end
        step(G, 1'b1, 1'b0);
        chk("s6.noerr", 32'(ifa.err_seq | ifa.err_code), 32'd0);
        step(R, 1'b1, 1'b0);

        // Reset while locked wins over enable
        step(Y, 1'b1, 1'b1);
        chk("s6.rlock",  32'(ifa.locked),      32'd0);
        chk("s6.rcyc",   32'(ifa.cycle_count), 32'd0);
        chk("s6.rerrs",  32'(ifa.err_count),   32'd0);
        chk("s6.rcolor", 32'(ifa.color),       32'd3);

        // Long clean run: 4-bit cycle counter wraps
        run_rgy(54);

        // Mixed traffic: mostly legal successors, some holds, junk and enable gaps
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 9))
                0:       l = 3'($urandom_range(0, 7));
                1:       l = (ma.prev < 3) ? seq[ma.prev] : R;
                default: l = seq[(ma.prev + 1) % 3];
            endcase
            step(l, ($urandom_range(0, 9) != 0), ($urandom_range(0, 59) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
